md_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in the E stage beside the ALU and consumes the 4-bit md class code produced by the decoder.
- Models real multi-cycle latency with a busy counter, so hazard logic can stall D-stage md instructions.
- Successor to the purely decoded mult/div handling: adds configurable width and latency, a start/busy handshake, defined divide corner cases, and an optional flush.

---
 rtl/md_unit_if.sv | 16 +
 rtl/md_unit.sv | 93 +++++++++
 tb/tb_md_unit.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// Pipeline <-> md_unit bundle: E-stage md request (valid/op/operands) and unit status, HI/LO and mfhi/mflo data.
// The master side is the pipeline and the slave side is md_unit.
interface md_unit_if #(parameter int WIDTH = 32);
   logic             md_valid;
   logic [3:0]       md_op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             start;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] rd_data;

   modport master (output md_valid, md_op, a, b, input start, busy, hi, lo, rd_data);
   modport slave  (input md_valid, md_op, a, b, output start, busy, hi, lo, rd_data);
endinterface

// File: rtl/md_unit.sv
// md_unit: mult/div with HI/LO; results land MULT_CYCLES/DIV_CYCLES edges after start; md ops seen while busy
// are dropped, so the pipeline stalls on start|busy. Defining MDU_FLUSH_EN adds a flush port that aborts an op.
module md_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input logic      clk,
   input logic      reset,
`ifdef MDU_FLUSH_EN
   input logic      flush,
`endif
   md_unit_if.slave bus
);
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   hi_q, lo_q, pend_hi, pend_lo;
   logic               pend_wr;
   logic               busy, kill;
   logic               is_mul, is_div, is_signed, accept, wr_hi, wr_lo;
   logic [2*WIDTH-1:0] prod;
   logic               neg_a, neg_b;
   logic [WIDTH-1:0]   mag_a, mag_b, div_b, uq, ur, quo, rem, res_hi, res_lo;

`ifdef MDU_FLUSH_EN
   assign kill = flush;
`else
   assign kill = 1'b0;
`endif

   assign busy      = (cnt != '0);
   assign is_mul    = (bus.md_op == 4'd1) || (bus.md_op == 4'd2);
   assign is_div    = (bus.md_op == 4'd3) || (bus.md_op == 4'd4);
   assign is_signed = (bus.md_op == 4'd1) || (bus.md_op == 4'd3);

   assign bus.start = bus.md_valid & (is_mul | is_div) & ~busy;
   assign accept    = bus.start & ~kill;
   assign wr_hi     = bus.md_valid & (bus.md_op == 4'd7) & ~busy & ~kill;
   assign wr_lo     = bus.md_valid & (bus.md_op == 4'd8) & ~busy & ~kill;

   // Sign-extending to 2*WIDTH makes the low 2*WIDTH bits of an unsigned product the exact signed product.
   assign prod = is_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b}
                           : {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

   // Signed divide works on magnitudes; most-negative / -1 wraps back to most-negative with remainder 0.
   assign neg_a  = is_signed & bus.a[WIDTH-1];
   assign neg_b  = is_signed & bus.b[WIDTH-1];
   assign mag_a  = neg_a ? -bus.a : bus.a;
   assign mag_b  = neg_b ? -bus.b : bus.b;
   assign div_b  = (mag_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
   assign uq     = mag_a / div_b;
   assign ur     = mag_a % div_b;
   assign quo    = (neg_a ^ neg_b) ? -uq : uq;
   assign rem    = neg_a ? -ur : ur;
   assign res_hi = is_mul ? prod[2*WIDTH-1:WIDTH] : rem;
   assign res_lo = is_mul ? prod[WIDTH-1:0]       : quo;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_wr <= 1'b0;
      end else if (kill && busy) begin
         cnt     <= '0;
         pend_wr <= 1'b0;
      end else begin
         if (accept) begin
            cnt     <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            // Divide by zero runs the full latency but never commits.
            pend_wr <= is_mul | (bus.b != '0);
         end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1) && pend_wr) begin
               hi_q <= pend_hi;
               lo_q <= pend_lo;
            end
         end
         if (wr_hi) hi_q <= bus.a;
         if (wr_lo) lo_q <= bus.a;
      end
   end

   assign bus.busy    = busy;
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
   assign bus.rd_data = (bus.md_op == 4'd5) ? hi_q :
                        (bus.md_op == 4'd6) ? lo_q : '0;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and randomized md_unit stimulus; expected HI/LO and busy length are queued at issue
// and checked by a monitor whenever busy falls.
module tb_md_unit;
   localparam int W  = 32;
   localparam int MC = 5;
   localparam int DC = 10;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
`ifdef MDU_FLUSH_EN
   logic flush;
`endif

   md_unit_if #(.WIDTH(W)) bus();

   md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
`ifdef MDU_FLUSH_EN
      .flush (flush),
`endif
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;
   exp_t        exp_q[$];
   logic [31:0] m_hi, m_lo;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
      end
   endfunction

   // Architectural result from plain 64-bit arithmetic; SV integer division already truncates toward zero.
   function automatic void model_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                                    output logic [31:0] rh, output logic [31:0] rl);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      rh = m_hi;
      rl = m_lo;
      case (op)
         4'd1: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
         4'd2: begin p = {32'h0, av} * {32'h0, bv}; rh = p[63:32]; rl = p[31:0]; end
         4'd3: if (bv != 0) begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
         4'd4: if (bv != 0) begin rl = av / bv; rh = av % bv; end
         default: ;
      endcase
   endfunction

   // Called right after a negedge; returns 1ns after the edge that samples the request.
   task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input bit v, input bit idle);
      bit          is_md;
      exp_t        e;
      logic [31:0] rh, rl;
      is_md        = (op >= 4'd1) && (op <= 4'd4);
      bus.md_valid = v;
      bus.md_op    = op;
      bus.a        = av;
      bus.b        = bv;
      #1;
      chk("start", {63'h0, bus.start}, {63'h0, v && idle && is_md});
      if (v && idle) begin
         if (is_md) begin
            model_op(op, av, bv, rh, rl);
            e.hi  = rh;
            e.lo  = rl;
            e.cyc = (op <= 4'd2) ? MC : DC;
            m_hi  = rh;
            m_lo  = rl;
            exp_q.push_back(e);
         end else if (op == 4'd7) begin
            m_hi = av;
         end else if (op == 4'd8) begin
            m_lo = av;
         end
      end
      @(posedge clk);
      #1;
      bus.md_valid = 1'b0;
      bus.md_op    = 4'd0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.busy && n < 40);
      chk("idle_timeout", {63'h0, bus.busy}, 64'h0);
   endtask

   task automatic read_check();
      bus.md_op = 4'd5;
      #1 chk("mfhi_rd_data", bus.rd_data, m_hi);
      bus.md_op = 4'd6;
      #1 chk("mflo_rd_data", bus.rd_data, m_lo);
      bus.md_op = 4'd0;
   endtask

   initial begin : monitor
      int   run;
      bit   prev;
      exp_t e;
      run  = 0;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.busy) begin
            run++;
         end else if (prev) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_completion", 64'h1, 64'h0);
            end else begin
               e = exp_q.pop_front();
               chk("busy_cycles", 64'(run), 64'(e.cyc));
               chk("hi_after_op", bus.hi, e.hi);
               chk("lo_after_op", bus.lo, e.lo);
            end
            run = 0;
         end
         prev = bus.busy;
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin : stim
      int          k;
      logic [3:0]  op;
      logic [31:0] av, bv;
      bit          v;
`ifdef MDU_FLUSH_EN
      logic [31:0] sv_hi, sv_lo;
      flush = 1'b0;
`endif
      reset        = 1'b0;
      bus.md_valid = 1'b0;
      bus.md_op    = 4'd0;
      bus.a        = '0;
      bus.b        = '0;
      m_hi         = '0;
      m_lo         = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      chk("reset_hi", bus.hi, 64'h0);
      chk("reset_lo", bus.lo, 64'h0);
      chk("reset_busy", {63'h0, bus.busy}, 64'h0);
      chk("reset_start", {63'h0, bus.start}, 64'h0);
      bus.md_op = 4'd5;
      #1 chk("reset_mfhi", bus.rd_data, 64'h0);
      bus.md_op = 4'd0;

      @(negedge clk); issue(4'd1, 32'hFFFFFFFE, 32'd3, 1, 1); wait_idle();
      chk("mult_hi", bus.hi, 64'hFFFFFFFF);
      chk("mult_lo", bus.lo, 64'hFFFFFFFA);
      @(negedge clk); issue(4'd2, 32'hFFFFFFFE, 32'd3, 1, 1); wait_idle();
      chk("multu_hi", bus.hi, 64'h00000002);
      chk("multu_lo", bus.lo, 64'hFFFFFFFA);
      @(negedge clk); issue(4'd3, 32'hFFFFFFF9, 32'd2, 1, 1); wait_idle();
      chk("div_lo", bus.lo, 64'hFFFFFFFD);
      chk("div_hi", bus.hi, 64'hFFFFFFFF);
      @(negedge clk); issue(4'd4, 32'd7, 32'd2, 1, 1); wait_idle();
      chk("divu_lo", bus.lo, 64'd3);
      chk("divu_hi", bus.hi, 64'd1);

      @(negedge clk); issue(4'd7, 32'h1234, 32'd0, 1, 1);
      @(negedge clk); issue(4'd8, 32'h5678, 32'd0, 1, 1);
      @(negedge clk); issue(4'd3, 32'd99, 32'd0, 1, 1); wait_idle();
      chk("div0_hi", bus.hi, 64'h1234);
      chk("div0_lo", bus.lo, 64'h5678);
      read_check();
      @(negedge clk); issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1, 1); wait_idle();
      chk("divovf_lo", bus.lo, 64'h80000000);
      chk("divovf_hi", bus.hi, 64'h0);

      // mtlo while busy is dropped; a mult issued in the cycle busy falls is accepted.
      @(negedge clk); issue(4'd1, 32'd3, 32'd5, 1, 1);
      @(negedge clk); issue(4'd8, 32'hAA, 32'd0, 1, 0);
      wait_idle();
      chk("mtlo_ignored_lo", bus.lo, 64'd15);
      issue(4'd1, 32'd7, 32'd9, 1, 1); wait_idle();
      chk("b2b_lo", bus.lo, 64'd63);

      // Reset one cycle into a mult aborts it and clears HI/LO.
      @(negedge clk); issue(4'd1, 32'h1111, 32'h2222, 1, 1);
      exp_q[exp_q.size()-1].hi  = '0;
      exp_q[exp_q.size()-1].lo  = '0;
      exp_q[exp_q.size()-1].cyc = 1;
      m_hi = '0;
      m_lo = '0;
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
      chk("abort_busy", {63'h0, bus.busy}, 64'h0);
      read_check();

      for (int i = 0; i < 40; i++) begin
         k = $urandom_range(0, 7);
         case (k)
            0: op = 4'd1;  1: op = 4'd2;  2: op = 4'd3;  3: op = 4'd4;
            4: op = 4'd7;  5: op = 4'd8;  6: op = 4'd5;  default: op = 4'd0;
         endcase
         av = $urandom;
         bv = $urandom;
         case ($urandom_range(0, 7))
            0: bv = '0;
            1: begin av = 32'h80000000; bv = 32'hFFFFFFFF; end
            2: bv = 32'($urandom_range(1, 15));
            default: ;
         endcase
         v = ($urandom_range(0, 5) != 0);
         @(negedge clk); issue(op, av, bv, v, 1);
         if (v && op >= 4'd1 && op <= 4'd4) wait_idle();
         if ($urandom_range(0, 2) == 0) begin
            @(negedge clk); read_check();
         end
      end

`ifdef MDU_FLUSH_EN
      sv_hi = m_hi;
      sv_lo = m_lo;
      @(negedge clk); issue(4'd4, 32'd1000, 32'd7, 1, 1);
      exp_q[exp_q.size()-1].hi  = sv_hi;
      exp_q[exp_q.size()-1].lo  = sv_lo;
      exp_q[exp_q.size()-1].cyc = 3;
      m_hi = sv_hi;
      m_lo = sv_lo;
      repeat (3) @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", {63'h0, bus.busy}, 64'h0);
      read_check();
      // flush alongside a start or an mthi: nothing is taken.
      bus.md_valid = 1'b1; bus.md_op = 4'd1; bus.a = 32'd5; bus.b = 32'd6; flush = 1'b1;
      @(posedge clk); #1;
      bus.md_op = 4'd7;
      @(posedge clk); #1;
      bus.md_valid = 1'b0; bus.md_op = 4'd0; flush = 1'b0;
      @(negedge clk);
      chk("flush_start_busy", {63'h0, bus.busy}, 64'h0);
      read_check();
`endif

      repeat (3) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
